// File: rtl/wb_reg_file.sv
// wb_reg_file: writeback stage plus the 32-entry architectural register file.
//
// This module selects the writeback value, which is either the load data or the ALU result.
// It commits that value to the GPR array on the rising clock edge. It also serves the two
// decode read ports. Those ports see a write in the same cycle it is presented
// (write-through bypass). The selected writeback value, address and enable are exported for
// the EX forwarding unit.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high; clears every GPR
//   w_reg_ctl_in   in   register-write enable from MEM/WB
//   mem_to_reg_in  in   1: write mem_data_in, 0: write alu_result_in
//   mem_data_in    in   load data from MEM/WB
//   alu_result_in  in   ALU result from MEM/WB
//   w_reg_addr_in  in   destination register from MEM/WB
//   r_addr_1/2     in   decode read addresses (rs/rt)
//   r_data_1/2     out  decode read data
//   wb_data_out    out  selected writeback value
//   wb_addr_out    out  writeback destination (pass-through)
//   wb_en_out      out  effective write enable
module wb_reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_reg_ctl_in,
  input  logic                  mem_to_reg_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic [ADDR_WIDTH-1:0] r_addr_1,
  input  logic [ADDR_WIDTH-1:0] r_addr_2,
  output logic [DATA_WIDTH-1:0] r_data_1,
  output logic [DATA_WIDTH-1:0] r_data_2,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  output logic [ADDR_WIDTH-1:0] wb_addr_out,
  output logic                  wb_en_out
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] gpr_q [Depth];
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_en;

  always_comb begin
    wb_data = mem_to_reg_in ? mem_data_in : alu_result_in;
    // A write to r0 is dropped. A write during reset is also dropped, so neither one
    // bypasses to the read ports or to the forwarding unit.
    wb_en   = w_reg_ctl_in && (w_reg_addr_in != '0) && !reset;
  end

  assign wb_data_out = wb_data;
  assign wb_addr_out = w_reg_addr_in;
  assign wb_en_out   = wb_en;

  // Entry 0 is never written. The reset clears it anyway, so the whole array has a
  // defined value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wb_en) begin
      gpr_q[w_reg_addr_in] <= wb_data;
    end
  end

  // During the reset cycle the array still holds stale data. The reads are masked so that
  // they return 0 while reset is asserted.
  always_comb begin
    r_data_1 = '0;
    if (!reset && (r_addr_1 != '0)) begin
      if (wb_en && (r_addr_1 == w_reg_addr_in)) begin
        r_data_1 = wb_data;
      end else begin
        r_data_1 = gpr_q[r_addr_1];
      end
    end
  end

  always_comb begin
    r_data_2 = '0;
    if (!reset && (r_addr_2 != '0)) begin
      if (wb_en && (r_addr_2 == w_reg_addr_in)) begin
        r_data_2 = wb_data;
      end else begin
        r_data_2 = gpr_q[r_addr_2];
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed self-checking bench for wb_reg_file.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_reg_ctl_in;
  logic        mem_to_reg_in;
  logic [31:0] mem_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  w_reg_addr_in;
  logic [4:0]  r_addr_1;
  logic [4:0]  r_addr_2;
  logic [31:0] r_data_1;
  logic [31:0] r_data_2;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_addr_out;
  logic        wb_en_out;

  int checks   = 0;
  int failures = 0;

  wb_reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .w_reg_ctl_in (w_reg_ctl_in),
    .mem_to_reg_in(mem_to_reg_in),
    .mem_data_in  (mem_data_in),
    .alu_result_in(alu_result_in),
    .w_reg_addr_in(w_reg_addr_in),
    .r_addr_1     (r_addr_1),
    .r_addr_2     (r_addr_2),
    .r_data_1     (r_data_1),
    .r_data_2     (r_data_2),
    .wb_data_out  (wb_data_out),
    .wb_addr_out  (wb_addr_out),
    .wb_en_out    (wb_en_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge. They are checked 2 units later, well
  // before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ctl, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wa, input logic [4:0] ra1,
                       input logic [4:0] ra2);
    reset         = rst;
    w_reg_ctl_in  = ctl;
    mem_to_reg_in = m2r;
    mem_data_in   = mem;
    alu_result_in = alu;
    w_reg_addr_in = wa;
    r_addr_1      = ra1;
    r_addr_2      = ra2;
    #2;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_1111, 5'd7, 5'd7, 5'd6);
    check_val("rst_en", {31'b0, wb_en_out}, 32'h0);
    check_val("rst_rd1", r_data_1, 32'h0);
    tick();

    // 1: write r5, then reset clears it
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd1, 5'd2);
    check_val("t1_wben", {31'b0, wb_en_out}, 32'h1);
    check_val("t1_wbdata", wb_data_out, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    check_val("t1_r5", r_data_1, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    check_val("t1_r5_inrst", r_data_1, 32'h0);
    tick();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(a), 5'(31 - a));
      check_val($sformatf("t1_clr1_r%0d", a), r_data_1, 32'h0);
      check_val($sformatf("t1_clr2_r%0d", 31 - a), r_data_2, 32'h0);
    end

    // 2: ALU then memory source for r8
    drive(1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0000_0042, 5'd8, 5'd0, 5'd0);
    check_val("t2_wbalu", wb_data_out, 32'h0000_0042);
    check_val("t2_wbaddr", {27'b0, wb_addr_out}, 32'd8);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
    check_val("t2_r8_alu", r_data_1, 32'h0000_0042);
    drive(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0011, 5'd8, 5'd0, 5'd8);
    check_val("t2_wbmem", wb_data_out, 32'hCAFE_F00D);
    check_val("t2_r8_byp", r_data_2, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
    check_val("t2_r8_mem", r_data_1, 32'hCAFE_F00D);

    // 3: both ports bypass the same write
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd3, 5'd3, 5'd3);
    check_val("t3_byp1", r_data_1, 32'h1234_5678);
    check_val("t3_byp2", r_data_2, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd8);
    check_val("t3_r3", r_data_1, 32'h1234_5678);
    check_val("t3_r8", r_data_2, 32'hCAFE_F00D);

    // 4: r0 is hardwired zero
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check_val("t4_wben", {31'b0, wb_en_out}, 32'h0);
    check_val("t4_r0_now", r_data_1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check_val("t4_r0_after", r_data_2, 32'h0);

    // 5: back-to-back writes to r9
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h1, 5'd9, 5'd9, 5'd9);
    check_val("t5_c1", r_data_1, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h2, 5'd9, 5'd9, 5'd9);
    check_val("t5_c2", r_data_1, 32'h2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    check_val("t5_c3", r_data_2, 32'h2);

    // 6: reset beats a concurrent write; a disabled write leaves state alone
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd4, 5'd4, 5'd4);
    check_val("t6_wben_rst", {31'b0, wb_en_out}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h99, 5'd4, 5'd4, 5'd9);
    check_val("t6_r4_clr", r_data_1, 32'h0);
    check_val("t6_r9_clr", r_data_2, 32'h0);
    check_val("t6_nobyp_en", {31'b0, wb_en_out}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hABCD_0004, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 1'bx, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 5'd4, 5'd4, 5'd0);
    check_val("t6_r4_noctl", r_data_1, 32'hABCD_0004);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    check_val("t6_r4_hold", r_data_1, 32'hABCD_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
